// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// Module   : msrv32_pkg
// Purpose  : Shared opcodes, fetch FSM encoding and boot address for msrv32.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package msrv32_pkg;

  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_BOOT_ADDRESS = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/msrv32_next_pc_mux.sv
// ---------------------------------------------------------------------------
// Module   : msrv32_next_pc_mux
// Purpose  : Priority select of the next PC (trap, mret, branch, sequential).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module msrv32_next_pc_mux (
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc_out,
  output logic [31:0] pc_plus_4_out
);

  always_comb begin
    pc_plus_4_out = pc_in + 32'd4;
    if (trap_taken_in) begin
      next_pc_out = trap_address_in;
    end else if (mret_in) begin
      next_pc_out = epc_in;
    end else if (branch_taken_in) begin
      // jalr semantics: the target's bit 0 is always discarded
      next_pc_out = {iadder_in[31:1], 1'b0};
    end else begin
      next_pc_out = pc_plus_4_out;
    end
  end

endmodule

`default_nettype wire

// File: rtl/msrv32_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// Module   : msrv32_pc_fetch_unit
// Purpose  : Architectural PC register and instruction-fetch handshake FSM.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module msrv32_pc_fetch_unit
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = DEFAULT_BOOT_ADDRESS
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iadder_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        stall_in,
  input  logic        i_ready_in,
  output logic [31:0] i_addr_out,
  output logic        i_req_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic        instr_valid_out,
  output logic        misaligned_instr_out
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_fetch_addr;
  logic [31:0]  w_fetch_addr_nxt;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_next_pc;
  logic         w_valid_nxt;
  logic         w_in_run;
  logic         w_advance;

  msrv32_next_pc_mux u_next_pc_mux (
    .trap_taken_in   (trap_taken_in),
    .trap_address_in (trap_address_in),
    .mret_in         (mret_in),
    .epc_in          (epc_in),
    .branch_taken_in (branch_taken_in),
    .iadder_in       (iadder_in),
    .pc_in           (pc_out),
    .next_pc_out     (w_next_pc),
    .pc_plus_4_out   (pc_plus_4_out)
  );

  assign w_in_run = ms_riscv32_mp_rst_n_in && (r_state == S_RUN);
  assign misaligned_instr_out = w_in_run && branch_taken_in && iadder_in[1]
                                && !trap_taken_in && !mret_in;
  // A trap always redirects, even over a stall or a misaligned target
  assign w_advance = w_in_run && (trap_taken_in || (!stall_in && !misaligned_instr_out));

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = pc_out;
    w_valid_nxt      = instr_valid_out;
    w_fetch_addr_nxt = r_fetch_addr;
    i_req_out        = 1'b0;
    i_addr_out       = r_fetch_addr;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        i_req_out = ms_riscv32_mp_rst_n_in;
        if (i_ready_in) begin
          w_pc_nxt    = r_fetch_addr;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_advance) begin
          i_req_out        = 1'b1;
          i_addr_out       = w_next_pc;
          w_fetch_addr_nxt = w_next_pc;
          if (i_ready_in) begin
            w_pc_nxt = w_next_pc;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_WAIT;
          end
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state         <= S_BOOT;
      pc_out          <= BOOT_ADDRESS;
      instr_valid_out <= 1'b0;
      r_fetch_addr    <= BOOT_ADDRESS;
    end else begin
      r_state         <= w_state_nxt;
      pc_out          <= w_pc_nxt;
      instr_valid_out <= w_valid_nxt;
      r_fetch_addr    <= w_fetch_addr_nxt;
    end
  end

endmodule

`default_nettype wire
